// File: rtl/cosim_adder_arbiter_if.sv
// Handshake bundle between NREQ requesters, the shared adder arbiter and its result consumer.
interface cosim_adder_arbiter_if #(
    parameter int NREQ = 4,
    parameter int BW   = 2
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_a;
    logic [NREQ*BW-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [BW:0]        rsp_c;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_c
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_c
    );
endinterface

// File: rtl/cosim_adder_arbiter.sv
// Round-robin arbiter sharing one b+a adder among NREQ requesters; results tagged with requester id.
// Optional transfer counter port txn_count enabled by defining COSIM_ADDER_ARB_STATS_EN.
module cosim_adder_arbiter #(
    parameter int NREQ = 4,
    parameter int BW   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    cosim_adder_arbiter_if.slave  bus,
    output logic                  busy
`ifdef COSIM_ADDER_ARB_STATS_EN
    ,
    output logic [15:0]           txn_count
`endif
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [IDW-1:0]  ptr_r;
    logic [IDW-1:0]  grant_s;
    logic            found_s;
    logic            accept_s;
    logic [NREQ-1:0] req_ready_s;
    logic            a_r;
    logic [BW-1:0]   b_r;
    logic [IDW-1:0]  id_r;
    logic            rsp_valid_r;
    logic [IDW-1:0]  rsp_id_r;
    logic [BW:0]     rsp_c_r;
    logic            busy_r;
    logic [IDW:0]    scan_s;

    // Round-robin scan starting at ptr; the extra sum bit keeps the wrap below NREQ for any NREQ.
    always_comb begin
        grant_s = '0;
        found_s = 1'b0;
        scan_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_s = {1'b0, ptr_r} + (IDW+1)'(k);
            if (scan_s >= (IDW+1)'(NREQ)) begin
                scan_s = scan_s - (IDW+1)'(NREQ);
            end else begin
                scan_s = scan_s;
            end
            if (!found_s && bus.req_valid[scan_s[IDW-1:0]]) begin
                found_s = 1'b1;
                grant_s = scan_s[IDW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state and the combinational one-hot accept, which is held low during reset.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        req_ready_s  = '0;
        case (state_r)
            IDLE: begin
                if (found_s && !reset) begin
                    accept_s     = 1'b1;
                    req_ready_s  = {{(NREQ-1){1'b0}}, 1'b1} << grant_s;
                    next_state_s = CALC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CALC: next_state_s = HOLD;
            HOLD: begin
                if (bus.rsp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Operand capture, adder result, pointer advance and busy flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_r       <= '0;
            a_r         <= 1'b0;
            b_r         <= '0;
            id_r        <= '0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_c_r     <= '0;
            busy_r      <= 1'b0;
        end else begin
            busy_r <= (next_state_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r  <= bus.req_a[grant_s];
                        b_r  <= bus.req_b[int'(grant_s)*BW +: BW];
                        id_r <= grant_s;
                    end
                end
                CALC: begin
                    rsp_c_r     <= {1'b0, b_r} + {{BW{1'b0}}, a_r};
                    rsp_id_r    <= id_r;
                    rsp_valid_r <= 1'b1;
                end
                HOLD: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        ptr_r       <= (id_r == IDW'(NREQ-1)) ? '0 : id_r + IDW'(1);
                    end
                end
                default: rsp_valid_r <= 1'b0;
            endcase
        end
    end

`ifdef COSIM_ADDER_ARB_STATS_EN
    logic [15:0] txn_count_r;

    // Completed result transfers, wrapping naturally at 16 bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            txn_count_r <= 16'd0;
        end else if (state_r == HOLD && bus.rsp_ready) begin
            txn_count_r <= txn_count_r + 16'd1;
        end
    end

    assign txn_count = txn_count_r;
`endif

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_c     = rsp_c_r;
    assign busy          = busy_r;
endmodule
